mem_stage: RTL and testbench

//   MIPS32 memory-access stage plus EX/MEM->MEM/WB pipeline register. Sits directly downstream of
//   the execute stage, consuming IR_ex, ALU_out and B_ex. Performs LW/SW on a word-addressed

---
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage.sv | 176 +++++++++++++++++
 tb/tb_mem_stage.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// -----------------------------------------------------------------------------
// mem_stage_if
//   Bundles the EX -> MEM handshake/operand signals and the MEM -> WB result
//   signals of the MIPS32 memory-access stage.
//
//   Signals
//     ex_valid      EX offers an instruction (IR_ex/ALU_out/B_ex valid)
//     ex_ready      stage can accept this cycle
//     IR_ex         instruction word from EX (opcode = IR_ex[31:26])
//     ALU_out       ALU result / effective byte address from EX
//     B_ex          store data from EX
//     mem_valid     one-cycle pulse, WB-side outputs valid
//     IR_mem        registered instruction for WB
//     ALU_out_mem   registered ALU result for WB
//     LMD           load data (updated by LW only)
//     halted        sticky, HLT has retired
//     misalign_err  sticky misaligned LW/SW flag (trap build only)
//
//   Modports
//     master  : upstream/downstream environment (drives EX side)
//     slave   : the mem_stage itself
// -----------------------------------------------------------------------------
interface mem_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] IR_ex;
  logic [31:0] ALU_out;
  logic [31:0] B_ex;
  logic        mem_valid;
  logic [31:0] IR_mem;
  logic [31:0] ALU_out_mem;
  logic [31:0] LMD;
  logic        halted;
  logic        misalign_err;

  modport master (
    output ex_valid, IR_ex, ALU_out, B_ex,
    input  ex_ready, mem_valid, IR_mem, ALU_out_mem, LMD, halted, misalign_err
  );

  modport slave (
    input  ex_valid, IR_ex, ALU_out, B_ex,
    output ex_ready, mem_valid, IR_mem, ALU_out_mem, LMD, halted, misalign_err
  );
endinterface

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   MIPS32 memory-access stage plus the EX/MEM -> MEM/WB pipeline register.
//   Executes LW/SW against a word-addressed internal data memory of
//   2**ADDR_W 32-bit words, with WAIT_STATES extra cycles per memory op.
//   Non-memory instructions pass straight through with one cycle latency.
//   HLT parks the stage in a halted state until reset.
//
//   Parameters
//     ADDR_W       word-address width (index = ALU_out[ADDR_W+1:2], wraps)
//     WAIT_STATES  extra cycles per LW/SW (0..15)
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   mem_stage_if.slave (EX handshake/operands, WB results, status)
//
//   Optional feature
//     MEM_MISALIGN_TRAP_EN : when defined, LW/SW with ALU_out[1:0] != 0 skip
//     the memory access but still retire, and set sticky misalign_err.
//     When undefined, the low address bits are ignored and misalign_err is 0.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst,
  mem_stage_if.slave bus
);

  localparam logic [5:0] OP_LW  = 6'b001000;
  localparam logic [5:0] OP_SW  = 6'b001001;
  localparam logic [5:0] OP_HLT = 6'b111111;
  localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);
  localparam int         DEPTH  = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HALT} state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  cnt_p0, cnt_nxt;

  // operands captured at accept, used when the access is deferred by waits
  logic [31:0] ir_p0, alu_p0, b_p0;

  // operands of the access performed at this edge (live or captured)
  logic [31:0] acc_ir, acc_alu, acc_b;
  logic [5:0]  acc_op;
  logic [ADDR_W-1:0] acc_idx;
  logic        capture, access, misal, wr_en, ld_en;

  // WB-facing registers
  logic        vld_p1;
  logic [31:0] ir_p1, alu_p1, lmd_p1;

  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Control: state and wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt_p0 <= 4'd0;
    end else begin
      state  <= state_nxt;
      cnt_p0 <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_p0;
    capture   = 1'b0;
    access    = 1'b0;
    acc_ir    = ir_p0;
    acc_alu   = alu_p0;
    acc_b     = b_p0;
    case (state)
      S_IDLE: begin
        if (bus.ex_valid) begin
          capture = 1'b1;
          if (is_mem_op(bus.IR_ex[31:26]) && (WAIT_STATES != 0)) begin
            cnt_nxt   = WS_CNT;
            state_nxt = S_WAIT;
          end else begin
            // zero-latency path: access uses the live EX operands
            access  = 1'b1;
            acc_ir  = bus.IR_ex;
            acc_alu = bus.ALU_out;
            acc_b   = bus.B_ex;
            if (bus.IR_ex[31:26] == OP_HLT) state_nxt = S_HALT;
          end
        end
      end
      S_WAIT: begin
        cnt_nxt = cnt_p0 - 4'd1;
        if (cnt_p0 == 4'd1) begin
          access    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  assign acc_op  = acc_ir[31:26];
  assign acc_idx = acc_alu[ADDR_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = is_mem_op(acc_op) && (acc_alu[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  // rst gates the write so an access coinciding with reset never lands
  assign wr_en = access && (acc_op == OP_SW) && !misal && !rst;
  assign ld_en = access && (acc_op == OP_LW) && !misal;

  // ---------------------------------------------------------------------------
  // Stage p0: operand capture at accept
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (capture) begin
      ir_p0  <= bus.IR_ex;
      alu_p0 <= bus.ALU_out;
      b_p0   <= bus.B_ex;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[acc_idx] <= acc_b;
  end

  // ---------------------------------------------------------------------------
  // Stage p1: MEM/WB register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ir_p1  <= 32'd0;
      alu_p1 <= 32'd0;
      lmd_p1 <= 32'd0;
    end else begin
      vld_p1 <= access;
      if (access) begin
        ir_p1  <= acc_ir;
        alu_p1 <= acc_alu;
      end
      if (ld_en) lmd_p1 <= mem[acc_idx];
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_p1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 mis_p1 <= 1'b0;
    else if (access && misal) mis_p1 <= 1'b1;
  end
  assign bus.misalign_err = mis_p1;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign bus.ex_ready    = (state == S_IDLE);
  assign bus.halted      = (state == S_HALT);
  assign bus.mem_valid   = vld_p1;
  assign bus.IR_mem      = ir_p1;
  assign bus.ALU_out_mem = alu_p1;
  assign bus.LMD         = lmd_p1;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
//   Directed bench for mem_stage. Three instances share clk/rst:
//   u0 (WAIT_STATES=0), u2 (WAIT_STATES=2), u3 (WAIT_STATES=3).
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  localparam logic [31:0] SW_I  = 32'h2400_0011;
  localparam logic [31:0] LW_I  = 32'h2000_0022;
  localparam logic [31:0] HLT_I = 32'hFC00_0000;
  localparam logic [31:0] ADD_I = 32'h0022_1820;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mem_stage_if if0 ();
  mem_stage_if if2 ();
  mem_stage_if if3 ();

  mem_stage #(.ADDR_W(10), .WAIT_STATES(0)) u0 (.clk(clk), .rst(rst), .bus(if0));
  mem_stage #(.ADDR_W(10), .WAIT_STATES(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
  mem_stage #(.ADDR_W(10), .WAIT_STATES(3)) u3 (.clk(clk), .rst(rst), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send0(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b);
    if0.ex_valid = 1'b1; if0.IR_ex = ir; if0.ALU_out = alu; if0.B_ex = b;
  endtask

  task automatic send2(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b);
    if2.ex_valid = 1'b1; if2.IR_ex = ir; if2.ALU_out = alu; if2.B_ex = b;
  endtask

  task automatic send3(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] b);
    if3.ex_valid = 1'b1; if3.IR_ex = ir; if3.ALU_out = alu; if3.B_ex = b;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    if0.ex_valid = 1'b0; if0.IR_ex = '0; if0.ALU_out = '0; if0.B_ex = '0;
    if2.ex_valid = 1'b0; if2.IR_ex = '0; if2.ALU_out = '0; if2.B_ex = '0;
    if3.ex_valid = 1'b0; if3.IR_ex = '0; if3.ALU_out = '0; if3.B_ex = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state
    chk1("rst_ready0", if0.ex_ready, 1'b1);
    chk1("rst_mv0", if0.mem_valid, 1'b0);
    chk("rst_ir0", if0.IR_mem, 32'h0);
    chk("rst_alu0", if0.ALU_out_mem, 32'h0);
    chk("rst_lmd0", if0.LMD, 32'h0);
    chk1("rst_halt0", if0.halted, 1'b0);
    chk1("rst_mis0", if0.misalign_err, 1'b0);
    chk1("rst_ready3", if3.ex_ready, 1'b1);
    tick;
    chk1("idle_mv0", if0.mem_valid, 1'b0);

    // zero-wait store then load of the same word, back to back
    send0(SW_I, 32'h40, 32'hDEADBEEF);
    tick;
    chk1("sw_mv", if0.mem_valid, 1'b1);
    chk("sw_ir", if0.IR_mem, SW_I);
    chk("sw_alu", if0.ALU_out_mem, 32'h40);
    chk("sw_lmd", if0.LMD, 32'h0);
    chk1("sw_ready", if0.ex_ready, 1'b1);
    send0(LW_I, 32'h40, 32'h0);
    tick;
    chk1("lw_mv", if0.mem_valid, 1'b1);
    chk("lw_ir", if0.IR_mem, LW_I);
    chk("lw_lmd", if0.LMD, 32'hDEADBEEF);
    if0.ex_valid = 1'b0;
    tick;
    chk1("gap_mv", if0.mem_valid, 1'b0);
    chk("gap_lmd", if0.LMD, 32'hDEADBEEF);

    // non-memory op passes through, LMD untouched
    send0(ADD_I, 32'h1234, 32'h5555);
    tick;
    chk1("add_mv", if0.mem_valid, 1'b1);
    chk("add_ir", if0.IR_mem, ADD_I);
    chk("add_alu", if0.ALU_out_mem, 32'h1234);
    chk("add_lmd", if0.LMD, 32'hDEADBEEF);
    chk1("add_ready", if0.ex_ready, 1'b1);
    if0.ex_valid = 1'b0;
    tick;

    // misaligned store to 0x41
    send0(SW_I, 32'h41, 32'h11111111);
    tick;
    chk1("mis_sw_mv", if0.mem_valid, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    chk1("mis_flag", if0.misalign_err, 1'b1);
`else
    chk1("mis_flag", if0.misalign_err, 1'b0);
`endif
    send0(LW_I, 32'h40, 32'h0);
    tick;
    chk1("mis_lw_mv", if0.mem_valid, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_lw_lmd", if0.LMD, 32'hDEADBEEF);
`else
    chk("mis_lw_lmd", if0.LMD, 32'h11111111);
`endif

    // address wrap: upper address bits are ignored
    send0(SW_I, 32'h0000_1008, 32'hCAFE0005);
    tick;
    send0(SW_I, 32'hFFFF_F00C, 32'h0C0C0C0C);
    tick;
    send0(LW_I, 32'h8, 32'h0);
    tick;
    chk("wrap_lmd8", if0.LMD, 32'hCAFE0005);
    chk("wrap_alu8", if0.ALU_out_mem, 32'h8);
    send0(LW_I, 32'hC, 32'h0);
    tick;
    chk("wrap_lmdc", if0.LMD, 32'h0C0C0C0C);
    if0.ex_valid = 1'b0;
    tick;

    // halt: sticky, blocks further accepts
    send0(HLT_I, 32'h0, 32'h0);
    tick;
    chk1("hlt_halted", if0.halted, 1'b1);
    chk1("hlt_ready", if0.ex_ready, 1'b0);
    chk1("hlt_mv", if0.mem_valid, 1'b1);
    chk("hlt_ir", if0.IR_mem, HLT_I);
    send0(ADD_I, 32'h777, 32'h0);
    tick;
    chk1("hlt_hold_ready", if0.ex_ready, 1'b0);
    chk1("hlt_hold_halted", if0.halted, 1'b1);
    chk1("hlt_hold_mv", if0.mem_valid, 1'b0);
    chk("hlt_hold_alu", if0.ALU_out_mem, 32'h0);
    if0.ex_valid = 1'b0;

    // WAIT_STATES=2: store, then load with stall timing
    send2(SW_I, 32'h20, 32'h0BADF00D);
    tick;
    if2.ex_valid = 1'b0;
    tick;
    tick;
    chk1("ws2_sw_mv", if2.mem_valid, 1'b1);
    send2(LW_I, 32'h20, 32'h0);
    chk1("ws2_rdy_t0", if2.ex_ready, 1'b1);
    tick;
    if2.ex_valid = 1'b0;
    chk1("ws2_rdy_t1", if2.ex_ready, 1'b0);
    chk1("ws2_mv_t1", if2.mem_valid, 1'b0);
    tick;
    chk1("ws2_rdy_t2", if2.ex_ready, 1'b0);
    chk1("ws2_mv_t2", if2.mem_valid, 1'b0);
    tick;
    chk1("ws2_mv_t3", if2.mem_valid, 1'b1);
    chk("ws2_lmd", if2.LMD, 32'h0BADF00D);
    chk("ws2_ir", if2.IR_mem, LW_I);
    chk1("ws2_rdy_t3", if2.ex_ready, 1'b1);
    tick;
    chk1("ws2_mv_pulse", if2.mem_valid, 1'b0);
    send2(ADD_I, 32'h99, 32'h0);
    tick;
    chk1("ws2_add_mv", if2.mem_valid, 1'b1);
    chk("ws2_add_alu", if2.ALU_out_mem, 32'h99);
    chk1("ws2_add_ready", if2.ex_ready, 1'b1);
    if2.ex_valid = 1'b0;

    // WAIT_STATES=3: reset in the middle of a pending store
    send3(SW_I, 32'h10, 32'h77);
    tick;
    if3.ex_valid = 1'b0;
    repeat (3) tick;
    chk1("ws3_pre_mv", if3.mem_valid, 1'b1);
    send3(SW_I, 32'h10, 32'h5A);
    tick;
    if3.ex_valid = 1'b0;
    tick;
    chk1("ws3_mid_ready", if3.ex_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk1("rst_async_ready3", if3.ex_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    chk1("rst3_mv", if3.mem_valid, 1'b0);
    chk("rst3_ir", if3.IR_mem, 32'h0);
    chk("rst3_alu", if3.ALU_out_mem, 32'h0);
    chk1("rst3_ready", if3.ex_ready, 1'b1);
    chk1("rst0_halted", if0.halted, 1'b0);
    chk1("rst0_ready", if0.ex_ready, 1'b1);
    chk("rst0_lmd", if0.LMD, 32'h0);
    repeat (4) tick;
    chk1("rst3_quiet_mv", if3.mem_valid, 1'b0);
    send3(LW_I, 32'h10, 32'h0);
    tick;
    if3.ex_valid = 1'b0;
    repeat (3) tick;
    chk1("ws3_lw_mv", if3.mem_valid, 1'b1);
    chk("ws3_lw_lmd", if3.LMD, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
